// File: rtl/lcd_char_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_char_ctrl_if
// Purpose  : Byte-write valid/ready handshake into the character LCD controller.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_char_ctrl_if;
    logic       in_valid;
    logic       in_rs;
    logic [7:0] in_byte;
    logic       in_ready;

    modport master (output in_valid, in_rs, in_byte, input in_ready);
    modport slave  (input in_valid, in_rs, in_byte, output in_ready);
endinterface
`default_nettype wire

// File: rtl/lcd_char_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_char_ctrl
// Purpose  : HD44780-class write-only character LCD controller with power-up
//            init, cursor tracking and per-command execution waits.
//            Optional line autowrap enabled by defining LCD_AUTOWRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_char_ctrl #(
    parameter int POWERUP_CYC  = 1500000,
    parameter int SETUP_CYC    = 10,
    parameter int EN_PULSE_CYC = 50,
    parameter int HOLD_CYC     = 10,
    parameter int CMD_WAIT_CYC = 4000,
    parameter int CLR_WAIT_CYC = 164000,
    parameter int COLS         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_char_ctrl_if.slave    bus,
    output logic              init_done,
    output logic              cur_line,
    output logic [5:0]        cur_col,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_en,
    output logic [7:0]        lcd_d
);

    localparam logic [31:0] c_pwrup_last = 32'(POWERUP_CYC - 1);
    localparam logic [31:0] c_setup_last = 32'(SETUP_CYC - 1);
    localparam logic [31:0] c_pulse_last = 32'(EN_PULSE_CYC - 1);
    localparam logic [31:0] c_hold_last  = 32'(HOLD_CYC - 1);
    localparam logic [31:0] c_cmd_last   = 32'(CMD_WAIT_CYC - 1);
    localparam logic [31:0] c_clr_last   = 32'(CLR_WAIT_CYC - 1);
    localparam logic [5:0]  c_last_col   = 6'd39;
    localparam logic [2:0]  c_last_init  = 3'd4;
`ifdef LCD_AUTOWRAP_EN
    localparam logic [5:0]  c_cols       = 6'(COLS);
`endif

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_SETUP     = 3'd2,
        ST_PULSE     = 3'd3,
        ST_HOLD      = 3'd4,
        ST_EXEC_WAIT = 3'd5,
        ST_IDLE      = 3'd6
`ifdef LCD_AUTOWRAP_EN
        ,
        ST_WRAP_LOAD = 3'd7
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        init_done_q, init_done_d;
    logic        in_ready_q, in_ready_d;
    logic        line_q, line_d;
    logic [5:0]  col_q, col_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic        lcd_en_q, lcd_en_d;
    logic [7:0]  lcd_d_q, lcd_d_d;
`ifdef LCD_AUTOWRAP_EN
    logic        wrap_pend_q, wrap_pend_d;
`endif

    logic [31:0] w_dur_last;
    logic        w_dur_done;
    logic        w_long_wait;
    logic [5:0]  w_col_inc;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    init_byte = 8'h38;
            3'd1:    init_byte = 8'h01;
            3'd2:    init_byte = 8'h0E;
            3'd3:    init_byte = 8'h06;
            default: init_byte = 8'h80;
        endcase
    endfunction

    // Clear and home take the long execution wait; the latched byte decides.
    assign w_long_wait = !lcd_rs_q &&
                         (lcd_d_q == 8'h01 || lcd_d_q == 8'h02 || lcd_d_q == 8'h03);
    assign w_col_inc   = col_q + 6'd1;

    always_comb begin
        w_dur_last = '0;
        case (state_q)
            ST_PWRUP:     w_dur_last = c_pwrup_last;
            ST_SETUP:     w_dur_last = c_setup_last;
            ST_PULSE:     w_dur_last = c_pulse_last;
            ST_HOLD:      w_dur_last = c_hold_last;
            ST_EXEC_WAIT: w_dur_last = w_long_wait ? c_clr_last : c_cmd_last;
            default:      w_dur_last = '0;
        endcase
    end

    assign w_dur_done = (cnt_q == w_dur_last);

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        line_d      = line_q;
        col_d       = col_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_d_d     = lcd_d_q;
`ifdef LCD_AUTOWRAP_EN
        wrap_pend_d = wrap_pend_q;
`endif
        case (state_q)
            ST_PWRUP: begin
                cnt_d = w_dur_done ? '0 : cnt_q + 32'd1;
                if (w_dur_done) state_d = ST_INIT_LOAD;
            end
            ST_INIT_LOAD: begin
                lcd_d_d  = init_byte(idx_q);
                lcd_rs_d = 1'b0;
                state_d  = ST_SETUP;
            end
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    lcd_d_d  = bus.in_byte;
                    lcd_rs_d = bus.in_rs;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d = w_dur_done ? '0 : cnt_q + 32'd1;
                if (w_dur_done) state_d = ST_PULSE;
            end
            ST_PULSE: begin
                cnt_d = w_dur_done ? '0 : cnt_q + 32'd1;
                if (w_dur_done) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                cnt_d = w_dur_done ? '0 : cnt_q + 32'd1;
                if (w_dur_done) begin
                    state_d = ST_EXEC_WAIT;
                    if (lcd_rs_q) begin
                        // DDRAM order: column 39 of one line is followed by column 0 of the other
                        if (col_q == c_last_col) begin
                            col_d  = '0;
                            line_d = ~line_q;
                        end else begin
                            col_d = w_col_inc;
                        end
`ifdef LCD_AUTOWRAP_EN
                        wrap_pend_d = (col_q != c_last_col) && (w_col_inc == c_cols);
`endif
                    end else if (w_long_wait) begin
                        line_d = 1'b0;
                        col_d  = '0;
                    end else if (lcd_d_q[7]) begin
                        if (lcd_d_q[6:0] <= 7'h27) begin
                            line_d = 1'b0;
                            col_d  = lcd_d_q[5:0];
                        end else if (lcd_d_q[6:0] >= 7'h40 && lcd_d_q[6:0] <= 7'h67) begin
                            line_d = 1'b1;
                            col_d  = lcd_d_q[5:0];
                        end
                    end
                end
            end
            ST_EXEC_WAIT: begin
                cnt_d = w_dur_done ? '0 : cnt_q + 32'd1;
                if (w_dur_done) begin
                    if (!init_done_q) begin
                        if (idx_q == c_last_init) begin
                            init_done_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = ST_INIT_LOAD;
                        end
                    end else begin
`ifdef LCD_AUTOWRAP_EN
                        state_d = wrap_pend_q ? ST_WRAP_LOAD : ST_IDLE;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef LCD_AUTOWRAP_EN
            ST_WRAP_LOAD: begin
                lcd_d_d     = line_q ? 8'h80 : 8'hC0;
                lcd_rs_d    = 1'b0;
                wrap_pend_d = 1'b0;
                state_d     = ST_SETUP;
            end
`endif
            default: state_d = ST_PWRUP;
        endcase

        in_ready_d = (state_d == ST_IDLE) && init_done_d;
        lcd_en_d   = (state_d == ST_PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= '0;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            in_ready_q  <= 1'b0;
            line_q      <= 1'b0;
            col_q       <= '0;
            lcd_rs_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
            lcd_d_q     <= '0;
`ifdef LCD_AUTOWRAP_EN
            wrap_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            in_ready_q  <= in_ready_d;
            line_q      <= line_d;
            col_q       <= col_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_en_q    <= lcd_en_d;
            lcd_d_q     <= lcd_d_d;
`ifdef LCD_AUTOWRAP_EN
            wrap_pend_q <= wrap_pend_d;
`endif
        end
    end

    assign bus.in_ready = in_ready_q;
    assign init_done    = init_done_q;
    assign cur_line     = line_q;
    assign cur_col      = col_q;
    assign lcd_rs       = lcd_rs_q;
    assign lcd_rw       = 1'b0;
    assign lcd_en       = lcd_en_q;
    assign lcd_d        = lcd_d_q;

endmodule
`default_nettype wire

// File: doc/lcd_char_ctrl.md
Name: lcd_char_ctrl

Overview:
Parametrised HD44780-class character LCD controller: 8-bit parallel write-only bus with timing in clock-cycle parameters. After reset it runs a power-up wait and a fixed 5-command init sequence (0x38, 0x01, 0x0E, 0x06, 0x80). It then accepts command/data bytes over a valid/ready handshake, tracks the cursor position, and applies per-command execution waits. It sits between system logic and the LCD pins.

Parameters:
POWERUP_CYC, 1500000, cycles from reset release before the first init command (15 ms at 100 MHz)
SETUP_CYC, 10, cycles lcd_rs/lcd_d are stable before lcd_en rises (>=1)
EN_PULSE_CYC, 50, cycles lcd_en is held high (>=1)
HOLD_CYC, 10, cycles lcd_d is held after lcd_en falls (>=1)
CMD_WAIT_CYC, 4000, execution wait after a normal command or data write
CLR_WAIT_CYC, 164000, execution wait after 0x01 (clear) or 0x02/0x03 (home)
COLS, 16, visible columns per line (1..40)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request to write in_byte
in_rs  in  1  0 = command, 1 = data (character)
in_byte  in  8  byte to write
in_ready  out  1  controller can accept a byte this cycle
init_done  out  1  init sequence complete; stays high until reset
cur_line  out  1  tracked cursor line (0/1)
cur_col  out  6  tracked cursor column (0..39)
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write; tied 0 (write-only)
lcd_en  out  1  LCD enable strobe
lcd_d  out  8  LCD data bus

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM goes to PWRUP; init index 0; wait counters cleared. Asserting rst_n mid-transfer aborts the transfer immediately (lcd_en drops to 0 at once) and restarts from PWRUP.
- FSM states: PWRUP -> INIT_LOAD -> SETUP -> PULSE -> HOLD -> EXEC_WAIT -> (INIT_LOAD | IDLE | WRAP_LOAD).
- PWRUP: count POWERUP_CYC cycles, then go to INIT_LOAD.
- INIT_LOAD: drive init byte [idx] with rs=0, then go to SETUP. After the 5th init byte's EXEC_WAIT: set init_done=1, go to IDLE.
- IDLE: in_ready=1 only in IDLE with init_done=1. A transfer occurs when in_valid&in_ready on cycle T. The byte and rs are captured; in_ready=0 from T+1; lcd_rs/lcd_d are driven at T+1.
- SETUP: lcd_en=0 for SETUP_CYC cycles.
- PULSE: lcd_en=1 for exactly EN_PULSE_CYC cycles.
- HOLD: lcd_en=0 for HOLD_CYC cycles. lcd_d and lcd_rs stay unchanged through HOLD and EXEC_WAIT.
- EXEC_WAIT: wait CLR_WAIT_CYC if the byte was a command in {0x01, 0x02, 0x03}; otherwise wait CMD_WAIT_CYC.
- Latency, IDLE to IDLE: 1 + SETUP_CYC + EN_PULSE_CYC + HOLD_CYC + wait cycles.
- Cursor tracking (updated at the end of HOLD):
  - Command 0x01/0x02/0x03: line=0, col=0.
  - Command with bit7=1: address A=byte[6:0]. A in 0x00..0x27 gives line 0, col A. A in 0x40..0x67 gives line 1, col A-0x40. Other A: position unchanged.
  - Data write: col increments, wrapping 39 -> 0 with line toggled (HD44780 DDRAM order).
  - Other commands: no change.
- in_valid while not ready: ignored, no buffering. The source must hold in_byte and in_rs stable while in_valid=1 and in_ready=0.
- Init bytes also update cursor tracking. After init: line=0, col=0.

Optional Feature:
LCD_AUTOWRAP_EN
- Defined: when a data write leaves col == COLS, enter WRAP_LOAD instead of IDLE. WRAP_LOAD issues the internal command 0xC0 (if line 0) or 0x80 (if line 1) through SETUP/PULSE/HOLD/EXEC_WAIT with CMD_WAIT_CYC. Cursor is updated accordingly and in_ready stays 0 until that command completes.
- Undefined: no WRAP_LOAD state; the cursor advances into off-screen DDRAM columns as above.

Test Plan:
Use POWERUP_CYC=20, SETUP_CYC=2, EN_PULSE_CYC=3, HOLD_CYC=2, CMD_WAIT_CYC=8, CLR_WAIT_CYC=30, COLS=4.
- Reset release: 20 cycles of idle bus; then 5 lcd_en pulses, each 3 cycles wide, with lcd_d=0x38, 0x01, 0x0E, 0x06, 0x80 and lcd_rs=0. Gap after 0x01 is 30 cycles, others 8. Then init_done=1, in_ready=1, cur_line=0, cur_col=0.
- Handshake on data 0x41 at cycle T: in_ready=0 at T+1; lcd_rs=1, lcd_d=0x41 at T+1; lcd_en high T+3..T+5; in_ready=1 again at T+16; cur_col=1.
- Command 0xC5: cur_line=1, cur_col=5. Then command 0x01 (wait 30 cycles): cur_line=0, cur_col=0. in_valid held high through busy periods: exactly one write per handshake.
- Autowrap, macro defined: write 4 data bytes from col 0. After the 4th, an extra pulse with lcd_rs=0, lcd_d=0xC0 follows; cur_line=1, cur_col=0. Macro undefined: no extra pulse; cur_col=4.
- Wrap at col 39: command 0xA7 then one data byte gives cur_line=1, cur_col=0.
- Reset mid-PULSE: rst_n=0 while lcd_en=1 gives lcd_en=0, in_ready=0, init_done=0 immediately. After release, the full init sequence repeats.
